reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file with per-register scoreboard (pending) bits.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 57 +++++
 rtl/reg_file_sb.sv | 84 ++++++++
 tb/tb_reg_file_sb.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Package for the reg_file_sb register file.
// Holds the default geometry, the index-width helper and the helper that
// locates one port's field inside a packed multi-port bus.
package rf_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 16;
  localparam int RF_NRD   = 2;

  // Index width for a file of 'depth' registers; at least one bit.
  function automatic int aw_of(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // LSB of port 'port' in a packed bus of 'w'-bit fields.
  function automatic int port_lsb(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard for reg_file_sb.
// Ports:
//   clk, rst        clock, async active-high reset
//   wr_en, wr_addr  writeback: clears the pending bit of wr_addr
//   sb_set, sb_addr issue: sets the pending bit of sb_addr
//   busy_vec        all pending bits, bit r = register r
//   err_dbl_set     sticky flag, issue to an already-pending register
// A set and a clear on the same register in one cycle leave it pending.
// With ZERO_REG != 0, register 0 is never pending and sets to it are dropped.
module rf_scoreboard #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  output logic [DEPTH-1:0] busy_vec,
  output logic             err_dbl_set
);

  logic [DEPTH-1:0] r_pend;
  logic             r_err;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             w_set_ok;
  logic             w_dbl;

  assign w_set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  // A same-cycle writeback to the set address retires the old producer,
  // so re-issuing to it is legitimate, not a double set.
  assign w_dbl = w_set_ok && r_pend[sb_addr] && !(wr_en && (wr_addr == sb_addr));

  always_comb begin
    w_pend_nxt = r_pend;
    if (wr_en)    w_pend_nxt[wr_addr] = 1'b0;
    if (w_set_ok) w_pend_nxt[sb_addr] = 1'b1;
    if (ZERO_REG != 0) w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_err  <= r_err | w_dbl;
    end
  end

  assign busy_vec    = r_pend;
  assign err_dbl_set = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register pending (scoreboard) bits.
// Ports:
//   clk, rst        clock, async active-high reset
//   wr_en/addr/data writeback port, also clears the pending bit
//   sb_set/sb_addr  issue port, marks the destination pending
//   rd_addr         NRD packed read indices, port i at [i*AW +: AW]
//   rd_data         NRD packed read data,   port i at [i*WIDTH +: WIDTH]
//   rd_busy         pending bit seen by each read port
//   busy_vec        all pending bits
//   err_dbl_set     sticky double-issue flag
// Build option: define RF_BYPASS_EN to forward wr_data (with busy=0) to any
// read port addressing the register being written in the same cycle.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw_of(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [DEPTH-1:0]     busy_vec,
  output logic                 err_dbl_set
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok;

  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .busy_vec   (busy_vec),
    .err_dbl_set(err_dbl_set)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_fwd;

    assign w_ra   = rd_addr[port_lsb(i, AW) +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

`ifdef RF_BYPASS_EN
    // Forwarding is held off during reset so reads show the cleared file.
    assign w_fwd = wr_en && !rst && (w_ra == wr_addr) && !w_zero;
`else
    assign w_fwd = 1'b0;
`endif

    assign rd_data[port_lsb(i, WIDTH) +: WIDTH] =
        w_zero ? '0 : (w_fwd ? wr_data : r_mem[w_ra]);
    assign rd_busy[i] = !w_zero && !w_fwd && busy_vec[w_ra];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        sb_set;
  logic [3:0]  sb_addr;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic [15:0] busy_vec;
  logic        err_dbl_set;

  int n_total = 0;
  int n_pass  = 0;

  reg_file_sb dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .busy_vec   (busy_vec),
    .err_dbl_set(err_dbl_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        sb;
    logic [3:0]  sa;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  eb;
    logic [15:0] ebv;
    logic        eerr;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic sb, input logic [3:0] sa,
                       input logic [3:0] ra0, input logic [3:0] ra1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    sb_set = sb; sb_addr = sa;
    rd_addr = {ra1, ra0};
  endtask

  initial begin
    // Each row: inputs driven for one cycle; expected outputs are those seen
    // before the following posedge (state from earlier rows only).
    //         we  wa     wd        sb  sa     ra0    ra1    e0        e1        eb     ebv       err
    tv[0]  = '{1, 4'd5, 16'hA5A5, 0, 4'd0, 4'd1, 4'd2, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0};
    tv[1]  = '{0, 4'd0, 16'h0000, 1, 4'd3, 4'd5, 4'd5, 16'hA5A5, 16'hA5A5, 2'b00, 16'h0000, 0};
    tv[2]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd3, 4'd5, 16'h0000, 16'hA5A5, 2'b01, 16'h0008, 0};
    tv[3]  = '{1, 4'd3, 16'h0042, 0, 4'd0, 4'd5, 4'd0, 16'hA5A5, 16'h0000, 2'b00, 16'h0008, 0};
    tv[4]  = '{1, 4'd0, 16'hFFFF, 1, 4'd0, 4'd3, 4'd3, 16'h0042, 16'h0042, 2'b00, 16'h0000, 0};
    tv[5]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0};
    tv[6]  = '{1, 4'd7, 16'h1111, 1, 4'd7, 4'd5, 4'd3, 16'hA5A5, 16'h0042, 2'b00, 16'h0000, 0};
    tv[7]  = '{0, 4'd0, 16'h0000, 1, 4'd7, 4'd7, 4'd3, 16'h1111, 16'h0042, 2'b01, 16'h0080, 0};
    tv[8]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd7, 4'd7, 16'h1111, 16'h1111, 2'b11, 16'h0080, 1};
    tv[9]  = '{1, 4'd7, 16'h2222, 0, 4'd0, 4'd5, 4'd12, 16'hA5A5, 16'h0000, 2'b00, 16'h0080, 1};
    tv[10] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd7, 4'd5, 16'h2222, 16'hA5A5, 2'b00, 16'h0000, 1};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd5, 4'd9);
    #2;
    chk("rst0_rd", rd_data, 32'h0);
    chk("rst0_busy", {30'd0, rd_busy}, 32'h0);
    chk("rst0_bv", {16'd0, busy_vec}, 32'h0);
    chk("rst0_err", {31'd0, err_dbl_set}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].sb, tv[i].sa, tv[i].ra0, tv[i].ra1);
      #1;
      chk($sformatf("v%0d_rd0", i), {16'd0, rd_data[15:0]}, {16'd0, tv[i].e0});
      chk($sformatf("v%0d_rd1", i), {16'd0, rd_data[31:16]}, {16'd0, tv[i].e1});
      chk($sformatf("v%0d_busy", i), {30'd0, rd_busy}, {30'd0, tv[i].eb});
      chk($sformatf("v%0d_bv", i), {16'd0, busy_vec}, {16'd0, tv[i].ebv});
      chk($sformatf("v%0d_err", i), {31'd0, err_dbl_set}, {31'd0, tv[i].eerr});
    end

    // Read-during-write on reg9, which is pending with old value 1234.
    @(negedge clk);
    drive(1, 4'd9, 16'h1234, 1, 4'd9, 4'd5, 4'd5);
    @(negedge clk);
    drive(1, 4'd9, 16'hBEEF, 0, 4'd0, 4'd9, 4'd5);
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_same_data", {16'd0, rd_data[15:0]}, 32'h0000BEEF);
    chk("byp_same_busy", {31'd0, rd_busy[0]}, 32'h0);
`else
    chk("byp_same_data", {16'd0, rd_data[15:0]}, 32'h00001234);
    chk("byp_same_busy", {31'd0, rd_busy[0]}, 32'h1);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4'd5, 4'd9);
    #1;
    chk("byp_next_data", {16'd0, rd_data[31:16]}, 32'h0000BEEF);
    chk("byp_next_busy", {31'd0, rd_busy[1]}, 32'h0);

    // Issue is never forwarded: busy rises only after the edge.
    @(negedge clk);
    drive(0, 0, 0, 1, 4'd10, 4'd10, 4'd5);
    #1;
    chk("set_same_busy", {31'd0, rd_busy[0]}, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4'd10, 4'd5);
    #1;
    chk("set_next_busy", {31'd0, rd_busy[0]}, 32'h1);

    // Random traffic, then an asynchronous reset between edges.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));
    end
    @(negedge clk);
    drive(1, 4'd6, 16'h7777, 1, 4'd6, 4'd6, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd", rd_data, 32'h0);
    chk("arst_busy", {30'd0, rd_busy}, 32'h0);
    chk("arst_bv", {16'd0, busy_vec}, 32'h0);
    chk("arst_err", {31'd0, err_dbl_set}, 32'h0);
    // Hold reset across an edge with a write and set pending; both are dropped.
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd6, 4'd5);
    #1;
    chk("post_rst_rd", rd_data, 32'h0);
    chk("post_rst_bv", {16'd0, busy_vec}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
